// File: rtl/regfile_dmem_unit.sv
// Storage/operand block of a single-cycle 32-bit MIPS-style datapath:
// 2**M x N register file, 2**DMEM_AW-word data memory and immediate sign extender.
module regfile_dmem_unit #(
  parameter int N       = 32,
  parameter int M       = 5,
  parameter int DMEM_AW = 6
) (
  input  logic         CLK,
  input  logic         rst,
  input  logic [N-1:0] instr,
  input  logic [M-1:0] write_reg,
  input  logic [N-1:0] write_data,
  input  logic         reg_write,
  input  logic [N-1:0] mem_addr,
  input  logic         mem_write,
  output logic [N-1:0] src_a,
  output logic [N-1:0] read_data_2,
  output logic [N-1:0] signimm,
  output logic [N-1:0] data_mem_out
);

  localparam int NREGS  = 2 ** M;
  localparam int NWORDS = 2 ** DMEM_AW;

  logic [N-1:0] regs [NREGS];
  logic [N-1:0] mem  [NWORDS];

  logic [M-1:0]       rs;
  logic [M-1:0]       rt;
  logic [DMEM_AW-1:0] word_index;

  assign rs         = instr[21 +: M];
  assign rt         = instr[16 +: M];
  // Byte offset and upper address bits are dropped: word-aligned, aliasing memory.
  assign word_index = mem_addr[DMEM_AW+1:2];

  logic unused_bits;
  assign unused_bits = ^{instr[N-1:21+M], mem_addr[N-1:DMEM_AW+2], mem_addr[1:0]};

  assign src_a        = (rs == '0) ? '0 : regs[rs];
  assign read_data_2  = (rt == '0) ? '0 : regs[rt];
  assign signimm      = {{(N-16){instr[15]}}, instr[15:0]};
  assign data_mem_out = mem[word_index];

  // Register 0 is never written so it stays at its reset value of zero.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (reg_write && (write_reg != '0)) begin
      regs[write_reg] <= write_data;
    end
  end

  // Store data is the pre-edge rt value, even when the same edge rewrites rt.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NWORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_write) begin
      mem[word_index] <= read_data_2;
    end
  end

endmodule

// File: tb/tb_regfile_dmem_unit.sv
// Self-checking bench for regfile_dmem_unit: directed cases plus randomized
// traffic compared against an array-based reference model.
module tb_regfile_dmem_unit;

  logic        CLK;
  logic        rst;
  logic [31:0] instr;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [31:0] src_a;
  logic [31:0] read_data_2;
  logic [31:0] signimm;
  logic [31:0] data_mem_out;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rf_m  [32];
  logic [31:0] mem_m [64];

  regfile_dmem_unit #(.N(32), .M(5), .DMEM_AW(6)) dut (
    .CLK          (CLK),
    .rst          (rst),
    .instr        (instr),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .reg_write    (reg_write),
    .mem_addr     (mem_addr),
    .mem_write    (mem_write),
    .src_a        (src_a),
    .read_data_2  (read_data_2),
    .signimm      (signimm),
    .data_mem_out (data_mem_out)
  );

  // Clock / reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input int rs, input int rt, input logic [15:0] imm);
    logic [31:0] w;
    w = 32'(($urandom_range(0, 63) << 26) | (rs << 21) | (rt << 16)) | {16'h0, imm};
    return w;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) rf_m[i] = 32'h0;
    for (int i = 0; i < 64; i++) mem_m[i] = 32'h0;
  endtask

  function automatic logic [31:0] exp_mem(input logic [31:0] addr);
    return mem_m[(addr >> 2) % 64];
  endfunction

  function automatic logic [31:0] exp_sext(input logic [15:0] imm);
    int v;
    v = (imm >= 16'h8000) ? int'(imm) - 65536 : int'(imm);
    return 32'(v);
  endfunction

  // Driver tasks
  task automatic drive(input logic [31:0] i, input logic [4:0] wr, input logic [31:0] wd,
                       input logic rw, input logic [31:0] addr, input logic mw);
    instr      = i;
    write_reg  = wr;
    write_data = wd;
    reg_write  = rw;
    mem_addr   = addr;
    mem_write  = mw;
  endtask

  task automatic check_outputs(input string tag);
    #1;
    check({tag, ".src_a"},        src_a,        rf_m[instr[25:21]]);
    check({tag, ".read_data_2"},  read_data_2,  rf_m[instr[20:16]]);
    check({tag, ".signimm"},      signimm,      exp_sext(instr[15:0]));
    check({tag, ".data_mem_out"}, data_mem_out, exp_mem(mem_addr));
  endtask

  // One clock edge; model updates from values presented before the edge.
  task automatic step();
    logic [31:0] store;
    store = rf_m[instr[20:16]];
    @(posedge CLK);
    if (rst) begin
      model_clear();
    end else begin
      if (mem_write) mem_m[(mem_addr >> 2) % 64] = store;
      if (reg_write && write_reg != 5'd0) rf_m[write_reg] = write_data;
    end
    @(negedge CLK);
  endtask

  initial begin
    model_clear();
    rst = 1'b1;
    drive(32'h0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(negedge CLK);
    rst = 1'b0;
    check_outputs("reset_state");

    // Register write, read before and after the edge
    drive(mk_instr(8, 8, 16'h0), 5'd8, 32'h12345678, 1'b1, 32'h0, 1'b0);
    #1 check("pre_edge_rs8", src_a, 32'h0);
    step();
    drive(mk_instr(8, 8, 16'h0), 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1 check("post_edge_rs8", src_a, 32'h12345678);
    check("post_edge_rt8", read_data_2, 32'h12345678);

    // Register zero ignores writes
    drive(mk_instr(0, 0, 16'h0), 5'd0, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0);
    step();
    drive(mk_instr(0, 0, 16'h0), 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1 check("reg0_src_a", src_a, 32'h0);
    check("reg0_rd2", read_data_2, 32'h0);

    // Sign extension boundaries
    drive(mk_instr(0, 0, 16'h8000), 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1 check("sext_8000", signimm, 32'hFFFF8000);
    drive(mk_instr(0, 0, 16'h7FFF), 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1 check("sext_7fff", signimm, 32'h00007FFF);
    drive(mk_instr(0, 0, 16'hFFFF), 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1 check("sext_ffff", signimm, 32'hFFFFFFFF);

    // Memory store / load with alias addresses
    drive(mk_instr(0, 0, 16'h0), 5'd9, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
    step();
    drive(mk_instr(0, 9, 16'h0), 5'd0, 32'h0, 1'b0, 32'h10, 1'b1);
    #1 check("mem_pre_edge", data_mem_out, 32'h0);
    step();
    drive(mk_instr(0, 9, 16'h0), 5'd0, 32'h0, 1'b0, 32'h10, 1'b0);
    #1 check("mem_0x10", data_mem_out, 32'hDEADBEEF);
    mem_addr = 32'h13;
    #1 check("mem_0x13", data_mem_out, 32'hDEADBEEF);
    mem_addr = 32'h110;
    #1 check("mem_0x110_wrap", data_mem_out, 32'hDEADBEEF);

    // Simultaneous register and memory write to the rt register
    drive(mk_instr(9, 9, 16'h0), 5'd9, 32'h1, 1'b1, 32'h20, 1'b1);
    step();
    drive(mk_instr(9, 9, 16'h0), 5'd0, 32'h0, 1'b0, 32'h20, 1'b0);
    #1 check("simul_mem", data_mem_out, 32'hDEADBEEF);
    check("simul_reg9", src_a, 32'h1);

    // Asynchronous reset mid-cycle with nonzero contents
    #2 rst = 1'b1;
    model_clear();
    #1 check("async_rst_reg9", src_a, 32'h0);
    check("async_rst_mem", data_mem_out, 32'h0);
    for (int r = 0; r < 32; r++) begin
      instr = mk_instr(r, 31 - r, 16'h0);
      mem_addr = 32'(r * 4);
      #1 check("rst_sweep_rs", src_a, 32'h0);
      check("rst_sweep_rt", read_data_2, 32'h0);
      check("rst_sweep_mem", data_mem_out, 32'h0);
    end
    @(negedge CLK);
    // Reset wins over both enables at the edge
    drive(mk_instr(5, 9, 16'h0), 5'd5, 32'hA5A5A5A5, 1'b1, 32'h20, 1'b1);
    step();
    rst = 1'b0;
    drive(mk_instr(5, 9, 16'h0), 5'd0, 32'h0, 1'b0, 32'h20, 1'b0);
    #1 check("rst_blocks_mem", data_mem_out, 32'h0);
    check("rst_blocks_reg", src_a, 32'h0);
    // First edge after release writes normally
    drive(mk_instr(5, 5, 16'h0), 5'd5, 32'hCAFEF00D, 1'b1, 32'h0, 1'b0);
    step();
    drive(mk_instr(5, 5, 16'h0), 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1 check("post_release_write", src_a, 32'hCAFEF00D);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      drive($urandom(), 5'($urandom_range(0, 31)), $urandom(),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3)) : $urandom(),
            1'($urandom_range(0, 1)));
      rst = ($urandom_range(0, 63) == 0);
      if (rst) model_clear();
      check_outputs("rand");
      step();
      rst = 1'b0;
    end
    drive(32'h0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    check_outputs("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_dmem_unit.md
Name: regfile_dmem_unit

Overview:
- Storage/operand block of the single-cycle 32-bit MIPS-style datapath.
- Combines three functions:
  - 32x32 register file with two combinational read ports and one clocked write port.
  - Word-organised data memory with combinational read and clocked write.
  - 16-to-32 sign extender for the immediate field.
- Sits between instruction memory/decode and the ALU.
- ALU result drives the memory address; the rt read value is the memory store data.

Parameters:
- N, 32, data/instruction word width in bits.
- M, 5, register address width; register file holds 2**M registers.
- DMEM_AW, 6, data memory word-index width; memory holds 2**DMEM_AW words.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr  input  N  current instruction; rs=instr[25:21], rt=instr[20:16], imm=instr[15:0].
- write_reg  input  M  destination register index.
- write_data  input  N  register write value (write-back result).
- reg_write  input  1  register write enable.
- mem_addr  input  N  data memory byte address (ALU result).
- mem_write  input  1  data memory write enable.
- src_a  output  N  register[rs].
- read_data_2  output  N  register[rt]; also the internal memory store data.
- signimm  output  N  sign-extended imm.
- data_mem_out  output  N  memory word at mem_addr.

Behaviour:
- Reset
  - rst high immediately (asynchronously) clears all 2**M registers and all 2**DMEM_AW memory words to 0.
  - While rst is high, no writes occur; rst wins over reg_write/mem_write on the same edge.
  - Reset released mid-operation: the next rising edge with enables set writes normally.
- Register file reads
  - src_a and read_data_2 are purely combinational from instr and current register contents (zero-cycle latency).
  - Register 0 always reads 0.
- Register file write
  - On rising CLK, if reg_write=1 and rst=0, register[write_reg] <= write_data.
  - A write with write_reg=0 is discarded.
- Read-during-write (register file)
  - Before the edge, reads return the old value; no write-through bypass.
  - The new value appears on the read outputs immediately after the edge.
- Data memory addressing
  - Word index = mem_addr[DMEM_AW+1:2].
  - mem_addr[1:0] ignored (word-aligned only, no byte/halfword access).
  - Upper address bits ignored, so addresses alias modulo 4*2**DMEM_AW bytes (wrap-around).
- Data memory read/write
  - data_mem_out is combinational from the current memory contents.
  - On rising CLK, if mem_write=1 and rst=0, mem[index] <= read_data_2 (value sampled before the edge).
  - Read-during-write returns the old word until the edge.
- Simultaneous register and memory write, same edge
  - Both occur.
  - The memory stores the pre-edge rt value, even if write_reg equals rt.
- Sign extend
  - signimm = {16 copies of instr[15], instr[15:0]}; combinational.
- General
  - No X on outputs after reset.
  - All outputs are deterministic for any instr.

Test Plan:
- Reset: pulse rst asynchronously mid-cycle with prior nonzero contents.
  - src_a, read_data_2 and data_mem_out read 0x00000000 for all rs/rt/addr.
- Register write/read:
  - reg_write=1, write_reg=8, write_data=0x12345678, edge; then rs=8, rt=8 → src_a=read_data_2=0x12345678.
  - Before the edge, rs=8 still reads 0.
- Register zero: write_reg=0, write_data=0xFFFFFFFF, edge → rs=0 reads 0x00000000.
- Sign extend:
  - instr[15:0]=0x8000 → signimm=0xFFFF8000.
  - 0x7FFF → 0x00007FFF.
  - 0xFFFF → 0xFFFFFFFF.
- Memory store/load:
  - reg9=0xDEADBEEF, rt=9, mem_addr=0x10, mem_write=1, edge; mem_write=0 → data_mem_out at 0x10 = 0xDEADBEEF.
  - mem_addr=0x13 also reads 0xDEADBEEF.
  - mem_addr=0x110 also reads 0xDEADBEEF (wrap, DMEM_AW=6).
- Simultaneous writes:
  - rt=9 (0xDEADBEEF), write_reg=9, write_data=0x1, reg_write=mem_write=1, mem_addr=0x20, edge.
  - Expected: mem[0x20]=0xDEADBEEF and reg9=0x00000001.
  - Assert rst with mem_write=1 at the edge → memory stays 0.
